// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants for the RISC-V core:
//   - NOP_INSN      : canonical NOP (addi x0, x0, 0)
//   - OPC_*         : major opcodes decoded by the control unit
//   - fetch_state_e : instruction-fetch sequencer states
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// ifetch_ctrl
// Instruction-fetch sequencer. Owns the PC, issues one-cycle word requests to a
// registered instruction memory, holds the returned instruction and grants the
// control unit a commit window (iready). Counts retired instructions and flags
// fetch timeouts / misaligned next-PC values (sticky until reset).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req          one-cycle request pulse (REQ state)
//   imem_addr         word address of the request (== pc)
//   imem_rvalid/rdata read response; only honoured in WAIT
//   pc_next           next PC selected by the datapath
//   stall             holds the current instruction uncommitted
//   pc, ins           PC and instruction currently held for the datapath
//   iready            commit enable (VALID and not stalled)
//   fetch_err         sticky timeout / misalignment flag
//   instret           committed-instruction counter (wraps at 2^32)
// -----------------------------------------------------------------------------
module ifetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15            // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [31:0] pc_next,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] ins,
    output logic        iready,
    output logic        fetch_err,
    output logic [31:0] instret
);

    // Counter value of the last WAIT cycle before a reissue: the counter runs
    // 0..TIMEOUT-1, so a timeout spends exactly TIMEOUT cycles in WAIT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ins_q, ins_d;
    logic [31:0]  instret_q, instret_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic         fetch_err_q, fetch_err_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        instret_d   = instret_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
        iready      = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
            end

            FETCH_REQ: begin
                wait_cnt_d = 8'd0;
                state_d    = FETCH_WAIT;
            end

            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    ins_d   = imem_rdata;
                    state_d = FETCH_VALID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Reissue the same PC; a late answer to the abandoned
                    // request lands in REQ and is ignored there.
                    fetch_err_d = 1'b1;
                    state_d     = FETCH_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            FETCH_VALID: begin
                // Combinational grant: the control unit may commit in the same
                // cycle the stall drops.
                iready = ~stall;
                if (!stall) begin
                    pc_d      = {pc_next[31:2], 2'b00};
                    instret_d = instret_q + 32'd1;
                    if (pc_next[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                    end
                    state_d = FETCH_REQ;
                end
            end

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            ins_q       <= NOP_INSN;
            instret_q   <= 32'd0;
            wait_cnt_q  <= 8'd0;
            fetch_err_q <= 1'b0;
        end else begin
            // NOTE: registers update with non-blocking assignments so every
            // flop samples the pre-edge value of its _d input.
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            instret_q   <= instret_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Moore outputs decoded from registered state.
    assign imem_req  = (state_q == FETCH_REQ);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ins       = ins_q;
    assign instret   = instret_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ifetch_ctrl
// Directed bench for ifetch_ctrl. Each scenario pushes the expected requests
// (address, cycle) and commits (pc, ins, instret, cycle) into queues; a monitor
// process pops and compares whenever the DUT raises imem_req or iready.
// A behavioural memory answers requests after a configurable latency, can drop
// requests, and keeps in-flight responses across reset.
// Inputs change 1 time unit after the rising edge; outputs sampled on negedge.
// -----------------------------------------------------------------------------
module tb_ifetch_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'd0;
    logic [31:0] pc_next     = 32'd4;
    logic        stall       = 1'b0;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        iready;
    logic        fetch_err;
    logic [31:0] instret;

    ifetch_ctrl #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_next     (pc_next),
        .stall       (stall),
        .pc          (pc),
        .ins         (ins),
        .iready      (iready),
        .fetch_err   (fetch_err),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ins;
        logic [31:0] instret;
        int          cyc;
    } exp_t;

    exp_t req_q[$];
    exp_t cmt_q[$];
    logic armed = 1'b0;

    // Cycle number since reset release: 0 = IDLE cycle, 1 = first REQ.
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0013;
    endfunction

    task automatic exp_req(input logic [31:0] a, input int c);
        exp_t e;
        e.addr = a; e.ins = 32'd0; e.instret = 32'd0; e.cyc = c;
        req_q.push_back(e);
    endtask

    task automatic exp_cmt(input logic [31:0] a, input logic [31:0] i, input logic [31:0] r, input int c);
        exp_t e;
        e.addr = a; e.ins = i; e.instret = r; e.cyc = c;
        cmt_q.push_back(e);
    endtask

    // ---------------- memory model ----------------
    int          mem_lat    = 0;      // wait cycles before rvalid
    int          drop_upto  = 0;      // drop requests while req_cnt < drop_upto
    logic        word_en    = 1'b0;
    logic [31:0] word_val   = 32'd0;
    int          req_cnt    = 0;
    logic        pend       = 1'b0;
    int          pend_cd    = 0;
    logic [31:0] pend_data  = 32'd0;

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (pend) begin
            if (pend_cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
                pend        = 1'b0;
            end else begin
                pend_cd = pend_cd - 1;
            end
        end
        if (imem_req) begin
            if (req_cnt >= drop_upto) begin
                pend      = 1'b1;
                pend_cd   = mem_lat;
                pend_data = word_en ? word_val : ins_of(imem_addr);
            end
            req_cnt = req_cnt + 1;
        end
    end

    // ---------------- datapath next-PC model ----------------
    logic        pcn_force_en = 1'b0;
    logic [31:0] pcn_force    = 32'd0;

    always @(posedge clk) begin
        #1;
        pc_next = pcn_force_en ? pcn_force : pc + 32'd4;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (armed && !rst) begin
            if (imem_req) begin
                check("req_expected", {31'd0, req_q.size() != 0}, 32'd1);
                if (req_q.size() != 0) begin
                    exp_t e;
                    e = req_q.pop_front();
                    check("req_addr", imem_addr, e.addr);
                    check("req_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (iready) begin
                check("commit_expected", {31'd0, cmt_q.size() != 0}, 32'd1);
                if (cmt_q.size() != 0) begin
                    exp_t e;
                    e = cmt_q.pop_front();
                    check("commit_pc", pc, e.addr);
                    check("commit_ins", ins, e.ins);
                    check("commit_instret", instret, e.instret);
                    check("commit_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic reset_dut();
        armed = 1'b0;
        rst   = 1'b1;
        req_q.delete();
        cmt_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_ins", ins, NOP_INSN);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_iready", {31'd0, iready}, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        int budget = 500;
        while (cyc != n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
    endtask

    task automatic wait_drain();
        int budget = 200;
        while ((req_q.size() != 0 || cmt_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("drain_req_q", 32'(req_q.size()), 32'd0);
        check("drain_cmt_q", 32'(cmt_q.size()), 32'd0);
        armed = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        // 1: zero-wait memory, sequential PC.
        mem_lat = 0; word_en = 1'b0; stall = 1'b0; pcn_force_en = 1'b0;
        reset_dut();
        drop_upto = req_cnt;
        exp_req(32'd0, 1);  exp_req(32'd4, 4);  exp_req(32'd8, 7);
        exp_req(32'd12, 10); exp_req(32'd16, 13);
        exp_cmt(32'd0,  ins_of(32'd0),  32'd0, 3);
        exp_cmt(32'd4,  ins_of(32'd4),  32'd1, 6);
        exp_cmt(32'd8,  ins_of(32'd8),  32'd2, 9);
        exp_cmt(32'd12, ins_of(32'd12), 32'd3, 12);
        armed = 1'b1;
        wait_drain();
        check("t1_instret", instret, 32'd4);
        check("t1_fetch_err", {31'd0, fetch_err}, 32'd0);

        // 2: three memory wait cycles.
        mem_lat = 3; word_en = 1'b1; word_val = 32'h0010_0093;
        reset_dut();
        drop_upto = req_cnt;
        exp_req(32'd0, 1); exp_req(32'd4, 7);
        exp_cmt(32'd0, 32'h0010_0093, 32'd0, 6);
        armed = 1'b1;
        wait_drain();
        check("t2_fetch_err", {31'd0, fetch_err}, 32'd0);
        word_en = 1'b0;

        // 3: stall held for four VALID cycles.
        mem_lat = 0; stall = 1'b1;
        reset_dut();
        drop_upto = req_cnt;
        exp_req(32'd0, 1); exp_req(32'd4, 8);
        exp_cmt(32'd0, ins_of(32'd0), 32'd0, 7);
        armed = 1'b1;
        wait_cyc(3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_iready_stalled", {31'd0, iready}, 32'd0);
            check("t3_pc_held", pc, 32'd0);
            check("t3_ins_held", ins, ins_of(32'd0));
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        wait_drain();
        check("t3_instret", instret, 32'd1);

        // 4: first request unanswered -> timeout, reissue answered 2nd cycle.
        mem_lat = 1;
        reset_dut();
        drop_upto = req_cnt + 1;
        exp_req(32'd0, 1); exp_req(32'd0, 17); exp_req(32'd4, 21);
        exp_cmt(32'd0, ins_of(32'd0), 32'd0, 20);
        armed = 1'b1;
        wait_cyc(16);
        @(negedge clk);
        check("t4_err_before_timeout", {31'd0, fetch_err}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t4_err_at_reissue", {31'd0, fetch_err}, 32'd1);
        wait_drain();
        check("t4_err_sticky", {31'd0, fetch_err}, 32'd1);

        // 5: misaligned pc_next at commit.
        mem_lat = 0; pcn_force_en = 1'b1; pcn_force = 32'h0000_0102;
        reset_dut();
        drop_upto = req_cnt;
        exp_req(32'd0, 1); exp_req(32'h0000_0100, 4);
        exp_cmt(32'd0, ins_of(32'd0), 32'd0, 3);
        armed = 1'b1;
        wait_drain();
        check("t5_fetch_err", {31'd0, fetch_err}, 32'd1);
        pcn_force_en = 1'b0;

        // 6: reset pulsed mid-WAIT; the in-flight response must be ignored.
        mem_lat = 2;
        reset_dut();
        drop_upto = req_cnt;
        exp_req(32'd0, 1); exp_req(32'd4, 6);
        exp_cmt(32'd0, ins_of(32'd0), 32'd0, 5);
        armed = 1'b1;
        wait_cyc(8);
        check("t6_pre_instret", instret, 32'd1);
        armed = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("t6_rst_pc", pc, 32'd0);
        check("t6_rst_ins", ins, NOP_INSN);
        check("t6_rst_instret", instret, 32'd0);
        check("t6_rst_iready", {31'd0, iready}, 32'd0);
        @(posedge clk);
        #1;
        exp_req(32'd0, 1); exp_req(32'd4, 6);
        exp_cmt(32'd0, ins_of(32'd0), 32'd0, 5);
        armed = 1'b1;
        rst   = 1'b0;
        @(negedge clk);
        check("t6_stale_ignored_ins", ins, NOP_INSN);
        wait_drain();
        check("t6_fetch_err", {31'd0, fetch_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch sequencer for the RISC-V core. It owns the program counter. It issues word requests to a registered instruction memory and holds the returned instruction. It raises `iready` to the control unit for exactly the cycles in which the datapath may commit that instruction. It also counts retired instructions and flags fetch timeouts. It sits between the instruction memory and the single-cycle datapath, which supplies `pc_next` (the `pcsel`-selected next PC).

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `TIMEOUT`, 15: WAIT cycles without `imem_rvalid` before the request is reissued; legal range 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `imem_req`  out  1: one-cycle request pulse.
- `imem_addr`  out  32: word address; equals `pc`, bits [1:0] always 0.
- `imem_rvalid`  in  1: read data valid; earliest one cycle after `imem_req`.
- `imem_rdata`  in  32: instruction word.
- `pc_next`  in  32: next PC from the datapath mux.
- `stall`  in  1: holds the current instruction uncommitted.
- `pc`  out  32: PC of the instruction in `ins`.
- `ins`  out  32: held instruction to the control unit and decoder.
- `iready`  out  1: commit enable to the control unit.
- `fetch_err`  out  1: sticky; set on timeout or a misaligned `pc_next`.
- `instret`  out  32: count of committed instructions.

## Operation
- FSM states are IDLE, REQ, WAIT and VALID. The state is registered; outputs are Moore except `iready`.
- Reset values:
  - state = IDLE, `pc` = RESET_PC.
  - `ins` = 32'h0000_0013 (NOP), `imem_req` = 0, `iready` = 0, `fetch_err` = 0, `instret` = 0.
  - Wait counter = 0.
- IDLE → REQ unconditionally. IDLE is occupied only in the first cycle after reset release.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - Always → WAIT. The wait counter clears.
- WAIT:
  - `imem_req` = 0.
  - If `imem_rvalid` = 1: `ins` ← `imem_rdata`, → VALID.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT-1 with no `imem_rvalid`: `fetch_err` ← 1, → REQ (same `pc`, reissue).
- VALID:
  - `iready` = ~`stall` (combinational).
  - If `stall` = 0: `pc` ← {`pc_next`[31:2], 2'b00}, `instret` ← `instret`+1 (32-bit wrap-around), → REQ.
  - If `stall` = 1: hold `pc`, `ins` and state.
- If `pc_next`[1:0] ≠ 0 at commit: `fetch_err` ← 1 and the low bits are forced to 0.
- `imem_rvalid` is ignored in IDLE, REQ and VALID. A late response from a timed-out request that arrives during REQ is dropped.
- `fetch_err` clears only on `rst`.
- `rst` asserted in any state returns to IDLE immediately. Any in-flight response is discarded because the controller is no longer in WAIT when the response arrives.

## Timing
- Zero-wait fetch: REQ at cycle n, `imem_rvalid` at n+1, VALID (`iready` = 1) at n+2, commit edge ends n+2, next REQ at n+3.
- Throughput is 3 cycles per instruction with zero-wait memory, plus 1 per memory wait cycle.
- `iready` is never high outside VALID and never high while `stall` = 1.
- `ins` and `pc` are stable for the whole VALID residency.
- After reset release: IDLE at cycle 0, first `imem_req` at cycle 1 with `imem_addr` = RESET_PC.
- A timeout costs exactly TIMEOUT WAIT cycles before the reissued REQ.

## Structure
- Shared package `riscv_pkg` holds:
  - the NOP encoding 32'h0000_0013;
  - the opcode constants already used by the control unit;
  - the fetch-state enum (IDLE, REQ, WAIT, VALID).
- Flat module. The wait counter is 8 bits, wide enough for TIMEOUT ≤ 255; no sub-module is warranted.

## Test plan
- Reset release with `imem_rvalid` returned every next cycle and `pc_next` = `pc`+4:
  - `imem_addr` sequence is 0, 4, 8, 12 on cycles 1, 4, 7, 10.
  - `instret` = 4 after the 4th VALID.
- Memory returns 32'h0010_0093 after 3 wait cycles: `iready` is first high 5 cycles after `imem_req`, `ins` = 32'h0010_0093, `fetch_err` = 0.
- `stall` held 4 cycles during VALID:
  - `iready` = 0 throughout the stall; `pc` and `ins` are unchanged.
  - Commit occurs on the first unstalled cycle; `instret` increments once.
- No `imem_rvalid` for 15 WAIT cycles:
  - `fetch_err` = 1 and a second `imem_req` is issued to the same address.
  - A response then arrives on the 2nd cycle after the reissued request: it is accepted normally and `fetch_err` stays 1.
- `pc_next` = 32'h0000_0102 at commit: next `imem_addr` = 32'h0000_0100 and `fetch_err` = 1.
- `rst` pulsed mid-WAIT, with `imem_rvalid` arriving the next cycle: outputs return to reset values, `ins` = NOP, the response is ignored, and the first post-reset request is to RESET_PC.
